// File: rtl/lcb_rx_pkg.sv
// Shared types and constants for the LCB response framer.
package lcb_rx_pkg;

    localparam int ADR_W = 5;
    localparam int CNT_W = 6;
    localparam int TMR_W = 14;

    localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FIRST = 3'd1,
        ST_RECEIVE    = 3'd2,
        ST_FILL       = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

endpackage

// File: rtl/lcb_rx_timer.sv
// Silence timer: counts while enabled, holds at the terminal count and flags
// expiry while the count equals it.
module lcb_rx_timer
    import lcb_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [TMR_W-1:0] tc_i,
    output logic             exp_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // next count: clear wins, then count up until the terminal value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {TMR_W{1'b0}};
        end else if (en_i && (cnt_q != tc_i)) begin
            cnt_d = cnt_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {TMR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exp_o = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/lcb_rx_framer.sv
// Response-window framer writing PKT_LEN bytes per window into the channel RAM.
// Optional: define LCB_RX_STAT_EN to add saturating timeout/short counters.
module lcb_rx_framer
    import lcb_rx_pkg::*;
#(
    parameter int         PKT_LEN   = 8,
    parameter int         RESP_TMO  = 8000,
    parameter int         GAP_TMO   = 800,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iStart,
    input  logic             iValid,
    input  logic [7:0]       iData,
    output logic [ADR_W-1:0] oWrAdr,
    output logic [7:0]       oWrData,
    output logic             oWE,
    output logic             oDone,
    output logic             oBusy,
    output logic             oTimeout,
`ifdef LCB_RX_STAT_EN
    output logic [15:0]      oTmoCnt,
    output logic [15:0]      oShortCnt,
`endif
    output logic             oShort
);

    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);
    localparam logic [TMR_W-1:0] RESP_TC   = TMR_W'(RESP_TMO - 1);
    localparam logic [TMR_W-1:0] GAP_TC    = TMR_W'(GAP_TMO - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              tmo_q, tmo_d;
    logic              short_q, short_d;

    logic [CNT_W-1:0]  cnt_inc_s;
    logic              byte_acc_s;
    logic              tmo_set_s;
    logic              short_set_s;
    logic              tmr_clr_s;
    logic              tmr_en_s;
    logic              tmr_exp_s;
    logic [TMR_W-1:0]  tmr_tc_s;

    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        busy_d      = busy_q;
        byte_acc_s  = 1'b0;
        tmo_set_s   = 1'b0;
        short_set_s = 1'b0;
        if (iStart) begin
            state_d = ST_WAIT_FIRST;
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_d = 1'b0;
                end
                ST_WAIT_FIRST, ST_RECEIVE: begin
                    if (iValid) begin
                        byte_acc_s = 1'b1;
                        we_d       = 1'b1;
                        adr_d      = cnt_q[ADR_W-1:0];
                        data_d     = iData;
                        cnt_d      = cnt_inc_s;
                        state_d    = (cnt_inc_s == PKT_LEN_C) ? ST_DONE : ST_RECEIVE;
                    end else if (tmr_exp_s) begin
                        tmo_set_s   = (state_q == ST_WAIT_FIRST);
                        short_set_s = (state_q == ST_RECEIVE);
                        state_d     = ST_FILL;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FILL: begin
                    // final address is PKT_LEN-1; cnt may reach 32 but never wraps into a write
                    if (cnt_q < PKT_LEN_C) begin
                        we_d    = 1'b1;
                        adr_d   = cnt_q[ADR_W-1:0];
                        data_d  = FILL_BYTE;
                        cnt_d   = cnt_inc_s;
                        state_d = (cnt_inc_s == PKT_LEN_C) ? ST_DONE : ST_FILL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
        tmo_d   = iStart ? 1'b0 : (tmo_q | tmo_set_s);
        short_d = iStart ? 1'b0 : (short_q | short_set_s);
    end

    assign tmr_clr_s = iStart | byte_acc_s | (state_d != state_q);
    assign tmr_en_s  = (state_q == ST_WAIT_FIRST) || (state_q == ST_RECEIVE);
    assign tmr_tc_s  = (state_q == ST_WAIT_FIRST) ? RESP_TC : GAP_TC;

    lcb_rx_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr_s),
        .en_i  (tmr_en_s),
        .tc_i  (tmr_tc_s),
        .exp_o (tmr_exp_s)
    );

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            adr_q   <= {ADR_W{1'b0}};
            data_q  <= 8'h00;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            short_q <= short_d;
        end
    end

    assign oWrAdr   = adr_q;
    assign oWrData  = data_q;
    assign oWE      = we_q;
    assign oDone    = done_q;
    assign oBusy    = busy_q;
    assign oTimeout = tmo_q;
    assign oShort   = short_q;

`ifdef LCB_RX_STAT_EN
    logic [15:0] tmo_cnt_q;
    logic [15:0] short_cnt_q;

    // saturating per-window event counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= 16'h0000;
            short_cnt_q <= 16'h0000;
        end else begin
            if (tmo_set_s && (tmo_cnt_q != 16'hFFFF)) begin
                tmo_cnt_q <= tmo_cnt_q + 16'h0001;
            end
            if (short_set_s && (short_cnt_q != 16'hFFFF)) begin
                short_cnt_q <= short_cnt_q + 16'h0001;
            end
        end
    end

    assign oTmoCnt   = tmo_cnt_q;
    assign oShortCnt = short_cnt_q;
`endif

endmodule

// File: tb/tb_lcb_rx_framer.sv
// Directed bench for lcb_rx_framer with default parameters (PKT_LEN=8).
module tb_lcb_rx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       iStart;
    logic       iValid;
    logic [7:0] iData;
    logic [4:0] oWrAdr;
    logic [7:0] oWrData;
    logic       oWE, oDone, oBusy, oTimeout, oShort;
`ifdef LCB_RX_STAT_EN
    logic [15:0] tmo_cnt, short_cnt;
`endif

    lcb_rx_framer dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iValid   (iValid),
        .iData    (iData),
        .oWrAdr   (oWrAdr),
        .oWrData  (oWrData),
        .oWE      (oWE),
        .oDone    (oDone),
        .oBusy    (oBusy),
        .oTimeout (oTimeout),
`ifdef LCB_RX_STAT_EN
        .oTmoCnt  (tmo_cnt),
        .oShortCnt(short_cnt),
`endif
        .oShort   (oShort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // write/done log captured mid-cycle
    logic [4:0] wr_adr [256];
    logic [7:0] wr_dat [256];
    int         wr_cyc [256];
    int         wr_n = 0;
    int         done_n = 0;
    int         done_cyc = 0;
    always @(negedge clk) begin
        if (oWE === 1'b1 && wr_n < 256) begin
            wr_adr[wr_n] <= oWrAdr;
            wr_dat[wr_n] <= oWrData;
            wr_cyc[wr_n] <= cyc;
            wr_n         <= wr_n + 1;
        end
        if (oDone === 1'b1) begin
            done_cyc <= cyc;
            done_n   <= done_n + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int vld_cyc [64];
    int vld_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        tick(gap);
        iValid = 1'b1;
        iData  = d;
        vld_cyc[vld_n] = cyc;
        vld_n++;
        tick(1);
        iValid = 1'b0;
    endtask

    task automatic pulse_start(output int cs);
        iStart = 1'b1;
        cs     = cyc;
        tick(1);
        iStart = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_adr"},   oWrAdr,   32'd0);
        check_eq({tag, "_dat"},   oWrData,  32'd0);
        check_eq({tag, "_we"},    oWE,      32'd0);
        check_eq({tag, "_done"},  oDone,    32'd0);
        check_eq({tag, "_busy"},  oBusy,    32'd0);
        check_eq({tag, "_tmo"},   oTimeout, 32'd0);
        check_eq({tag, "_short"}, oShort,   32'd0);
    endtask

    initial begin
        int base, dbase, vb, cs, lv;
        rst = 1'b1; iStart = 1'b0; iValid = 1'b0; iData = 8'h00;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);

        // stray byte while idle
        base = wr_n;
        send_byte(8'h55, 0);
        tick(3);
        check_eq("stray_we", wr_n - base, 32'd0);

        // full packet, bytes spaced 87 cycles
        base = wr_n; dbase = done_n; vb = vld_n;
        pulse_start(cs);
        check_eq("full_busy_hi", oBusy, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 86);
        tick(3);
        check_eq("full_nwr", wr_n - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq("full_adr", wr_adr[base+i], i);
            check_eq("full_dat", wr_dat[base+i], 32'h10 + i);
            check_eq("full_lat", wr_cyc[base+i], vld_cyc[vb+i] + 1);
        end
        check_eq("full_done_n",   done_n - dbase, 32'd1);
        check_eq("full_done_cyc", done_cyc, vld_cyc[vb+7] + 2);
        check_eq("full_tmo",      oTimeout, 32'd0);
        check_eq("full_short",    oShort, 32'd0);
        check_eq("full_busy_lo",  oBusy, 32'd0);

        // overrun byte after the window closed
        send_byte(8'h18, 2);
        tick(3);
        check_eq("overrun_we", wr_n - base, 32'd8);

        // no response: window fills after RESP_TMO
        base = wr_n; dbase = done_n;
        pulse_start(cs);
        tick(7990);
        check_eq("nores_tmo_early", oTimeout, 32'd0);
        tick(30);
        check_eq("nores_tmo",   oTimeout, 32'd1);
        check_eq("nores_short", oShort, 32'd0);
        check_eq("nores_nwr",   wr_n - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq("nores_adr", wr_adr[base+i], i);
            check_eq("nores_dat", wr_dat[base+i], 32'hFF);
            check_eq("nores_cyc", wr_cyc[base+i], cs + 8002 + i);
        end
        check_eq("nores_done_n",   done_n - dbase, 32'd1);
        check_eq("nores_done_cyc", done_cyc, cs + 8010);

        // short packet: 3 bytes then silence
        base = wr_n; dbase = done_n; vb = vld_n;
        pulse_start(cs);
        check_eq("short_tmo_clr", oTimeout, 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 10);
        lv = vld_cyc[vb+2];
        tick(820);
        check_eq("short_flag", oShort, 32'd1);
        check_eq("short_tmo",  oTimeout, 32'd0);
        check_eq("short_nwr",  wr_n - base, 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq("short_adr", wr_adr[base+i], i);
            check_eq("short_dat", wr_dat[base+i], (i < 3) ? (32'hA0 + i) : 32'hFF);
        end
        check_eq("short_fill_cyc", wr_cyc[base+3], lv + 802);
        check_eq("short_done_n",   done_n - dbase, 32'd1);

        // byte on the exact gap expiry cycle, then abort after 4 bytes
        base = wr_n; dbase = done_n;
        pulse_start(cs);
        check_eq("race_short_clr", oShort, 32'd0);
        send_byte(8'hC0, 5);
        send_byte(8'hC1, 799);
        send_byte(8'hC2, 5);
        send_byte(8'hC3, 5);
        tick(2);
        check_eq("race_short", oShort, 32'd0);
        check_eq("race_nwr",   wr_n - base, 32'd4);
        check_eq("race_adr1",  wr_adr[base+1], 32'd1);
        check_eq("race_dat1",  wr_dat[base+1], 32'hC1);
        iStart = 1'b1; iValid = 1'b1; iData = 8'hEE;
        tick(1);
        iStart = 1'b0; iValid = 1'b0;
        tick(5);
        check_eq("abort_drop",   wr_n - base, 32'd4);
        check_eq("abort_nodone", done_n - dbase, 32'd0);
        send_byte(8'hD0, 5);
        tick(2);
        check_eq("abort_adr0", wr_adr[base+4], 32'd0);
        check_eq("abort_dat0", wr_dat[base+4], 32'hD0);
        for (int i = 1; i < 8; i++) send_byte(8'hD0 + 8'(i), 3);
        tick(3);
        check_eq("abort_nwr",    wr_n - base, 32'd12);
        check_eq("abort_adr7",   wr_adr[base+11], 32'd7);
        check_eq("abort_done_n", done_n - dbase, 32'd1);

        // reset in the middle of RECEIVE
        base = wr_n; dbase = done_n;
        pulse_start(cs);
        send_byte(8'hE0, 5);
        send_byte(8'hE1, 5);
        tick(3);
        rst = 1'b1; iValid = 1'b1; iData = 8'hE2;
        tick(1);
        check_idle_outputs("rst_mid");
`ifdef LCB_RX_STAT_EN
        check_eq("stat_tmo_rst",   tmo_cnt, 32'd0);
        check_eq("stat_short_rst", short_cnt, 32'd0);
`endif
        rst = 1'b0; iValid = 1'b0;
        tick(900);
        check_eq("rst_nodone", done_n - dbase, 32'd0);
        check_eq("rst_nwr",    wr_n - base, 32'd2);

`ifdef LCB_RX_STAT_EN
        // three no-response windows
        for (int w = 0; w < 3; w++) begin
            pulse_start(cs);
            tick(8020);
        end
        check_eq("stat_tmo",   tmo_cnt, 32'd3);
        check_eq("stat_short", short_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
